// File: rtl/segre_mem_responder.sv
// Main-memory responder below the MMU: one lane read or sub-word store per transaction, fixed latency.
// Optional misaligned-store detection and err_o port: define SEGRE_MEM_MISALIGN_CHECK_EN.
module segre_mem_responder #(
   parameter int unsigned LANE_SIZE = 128,
   parameter int unsigned NUM_LANES = 1024,
   parameter int unsigned LATENCY   = 4,
   parameter int unsigned ADDR_SIZE = 32,
   parameter int unsigned WORD_SIZE = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rd_i,
   input  logic                 wr_i,
   input  logic [ADDR_SIZE-1:0] addr_i,
   input  logic [1:0]           wr_data_type_i,
   input  logic [WORD_SIZE-1:0] wr_data_i,
   output logic                 busy_o,
   output logic                 data_rdy_o,
   output logic [LANE_SIZE-1:0] rd_data_o
`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
   ,output logic                err_o
`endif
);

   localparam int unsigned LANE_BYTES = LANE_SIZE / 8;
   localparam int unsigned BYTE_OFS   = $clog2(LANE_BYTES);
   localparam int unsigned IDX_W      = $clog2(NUM_LANES);
   localparam int unsigned LA_W       = BYTE_OFS + IDX_W;
   localparam int unsigned CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 accept;

   logic [LA_W-1:0]      addr_q;
   logic [1:0]           type_q;
   logic [WORD_SIZE-1:0] data_q;
   logic                 wr_q;
   logic                 store_q;
   logic                 err_q;

   logic [LANE_SIZE-1:0] mem [NUM_LANES];

   logic [LA_W-1:0]      sel_addr;
   logic [1:0]           sel_type;
   logic [WORD_SIZE-1:0] sel_data;
   logic                 sel_wr;
   logic [IDX_W-1:0]     sel_idx;
   int unsigned          nbytes, ofs_u, base;
   logic                 misaligned, store_en;
   logic [WORD_SIZE-1:0] shifted;
   logic [LANE_SIZE-1:0] merged;

   logic unused_addr;
   assign unused_addr = ^addr_i[ADDR_SIZE-1:LA_W] ^ err_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      accept     = 1'b0;
      busy_o     = 1'b0;
      data_rdy_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_i | wr_i) begin
               accept  = 1'b1;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            busy_o = 1'b1;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_d == '0) state_d = RESP;
         end
         RESP: begin
            busy_o     = 1'b1;
            data_rdy_o = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // With LATENCY=1 the lane is merged on the accept edge, so use the live inputs in IDLE.
   always_comb begin
      sel_addr = (state_q == IDLE) ? addr_i[LA_W-1:0] : addr_q;
      sel_type = (state_q == IDLE) ? wr_data_type_i   : type_q;
      sel_data = (state_q == IDLE) ? wr_data_i        : data_q;
      sel_wr   = (state_q == IDLE) ? wr_i             : wr_q;
      sel_idx  = sel_addr[BYTE_OFS +: IDX_W];
      case (sel_type)
         2'b00:   nbytes = 1;
         2'b01:   nbytes = 2;
         2'b10:   nbytes = 4;
         default: nbytes = 0;
      endcase
      ofs_u = 32'(sel_addr[BYTE_OFS-1:0]);
      base  = ofs_u & ~(nbytes - 1);
      misaligned = sel_wr && (nbytes != 0) && ((ofs_u & (nbytes - 1)) != 0);
`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
      store_en = sel_wr && (nbytes != 0) && !misaligned;
`else
      store_en = sel_wr && (nbytes != 0);
`endif
      merged  = mem[sel_idx];
      shifted = '0;
      for (int unsigned i = 0; i < LANE_BYTES; i++) begin
         if (store_en && (i >= base) && (i < base + nbytes)) begin
            shifted          = sel_data >> (8 * (i - base));
            merged[8*i +: 8] = shifted[7:0];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         type_q    <= '0;
         data_q    <= '0;
         wr_q      <= 1'b0;
         store_q   <= 1'b0;
         err_q     <= 1'b0;
         rd_data_o <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q <= addr_i[LA_W-1:0];
            type_q <= wr_data_type_i;
            data_q <= wr_data_i;
            wr_q   <= wr_i;
         end
         if (state_d == RESP) begin
            rd_data_o <= merged;
            store_q   <= store_en;
            err_q     <= misaligned;
         end
      end
   end

   // Commit on the edge leaving RESP; an async reset forces IDLE first, dropping the store.
   always_ff @(posedge clk_i) begin
      if (state_q == RESP && store_q) mem[addr_q[BYTE_OFS +: IDX_W]] <= rd_data_o;
   end

`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
   assign err_o = (state_q == RESP) && err_q;
`endif

endmodule

// File: tb/tb_segre_mem_responder.sv
// Directed bench for segre_mem_responder with a transaction-level reference model.
module tb_segre_mem_responder;
   localparam int unsigned LANE_SIZE = 128;
   localparam int unsigned NUM_LANES = 1024;
   localparam int unsigned LATENCY   = 4;

   logic         clk = 1'b0;
   logic         rst, rd_i, wr_i;
   logic [31:0]  addr_i, wr_data_i;
   logic [1:0]   wr_data_type_i;
   logic         busy_o, data_rdy_o, err_v;
   logic [127:0] rd_data_o;

   int checks = 0;
   int errors = 0;
   logic data_chk = 1'b0;

   always #5 clk = ~clk;

   segre_mem_responder #(
      .LANE_SIZE(LANE_SIZE), .NUM_LANES(NUM_LANES), .LATENCY(LATENCY),
      .ADDR_SIZE(32), .WORD_SIZE(32)
   ) dut (
      .clk_i(clk), .rst_i(rst), .rd_i(rd_i), .wr_i(wr_i), .addr_i(addr_i),
      .wr_data_type_i(wr_data_type_i), .wr_data_i(wr_data_i),
      .busy_o(busy_o), .data_rdy_o(data_rdy_o), .rd_data_o(rd_data_o)
`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
      , .err_o(err_v)
`endif
   );
`ifndef SEGRE_MEM_MISALIGN_CHECK_EN
   assign err_v = 1'b0;
`endif

   function automatic int unsigned size_of(input logic [1:0] t);
      return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : (t == 2'd2) ? 4 : 0;
   endfunction

   function automatic logic is_bad(input logic wr, input logic [31:0] a, input logic [1:0] t);
      int unsigned n = size_of(t);
`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
      return wr && n != 0 && ((a % 16) % n) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [127:0] apply_store(input logic [127:0] lane, input logic wr,
                                                 input logic [31:0] a, input logic [1:0] t,
                                                 input logic [31:0] d);
      logic [127:0] r;
      int unsigned n, off, base;
      r = lane;
      n = size_of(t);
      off = a % 16;
      if (!wr || n == 0 || is_bad(wr, a, t)) return r;
      base = off - (off % n);
      for (int unsigned b = 0; b < n; b++) r[(base + b)*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   // Reference: accept when idle; busy for LATENCY cycles, pulse on the last one.
   logic [127:0] m_mem [NUM_LANES];
   int unsigned  m_rem;
   logic [127:0] m_rd;
   logic         t_wr, t_bad;
   logic [31:0]  t_addr, t_data;
   logic [1:0]   t_type;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_rem <= 0;
         m_rd  <= '0;
         t_bad <= 1'b0;
      end else if (m_rem == 0) begin
         if (rd_i | wr_i) begin
            m_rem  <= LATENCY;
            t_wr   <= wr_i;
            t_addr <= addr_i;
            t_type <= wr_data_type_i;
            t_data <= wr_data_i;
            t_bad  <= is_bad(wr_i, addr_i, wr_data_type_i);
         end
      end else begin
         m_rem <= m_rem - 1;
         if (m_rem == 2)
            m_rd <= apply_store(m_mem[(t_addr / 16) % NUM_LANES], t_wr, t_addr, t_type, t_data);
         if (m_rem == 1) m_mem[(t_addr / 16) % NUM_LANES] <= m_rd;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      check("busy_o", 128'(busy_o), 128'(m_rem != 0));
      check("data_rdy_o", 128'(data_rdy_o), 128'(m_rem == 1));
      if (data_chk) check("rd_data_o", rd_data_o, m_rd);
`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
      check("err_o", 128'(err_v), 128'((m_rem == 1) && t_bad));
`endif
   endtask

   task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] t,
                      input logic [31:0] d, output logic [127:0] lane, output logic err);
      logic got = 1'b0;
      lane = '0;
      err  = 1'b0;
      rd_i = rd; wr_i = wr; addr_i = a; wr_data_type_i = t; wr_data_i = d;
      for (int k = 0; k < 20 && !got; k++) begin
         step();
         if (data_rdy_o) begin
            got  = 1'b1;
            lane = rd_data_o;
            err  = err_v;
         end
      end
      if (!got) check("txn_timeout", 128'(got), 128'(1'b1));
      rd_i = 1'b0; wr_i = 1'b0;
      step();
   endtask

   function automatic logic [31:0] init_word(input int unsigned l, input int unsigned w);
      return 32'hC0DE_0000 | 32'(l << 8) | 32'(w);
   endfunction

   initial begin
      logic [127:0] lane, lane_a;
      logic err;
      int unsigned lanes [5] = '{0, 1, 2, 4, 16};
      int busy_n, pulse_at, pulses;

      rst = 1'b1; rd_i = 1'b0; wr_i = 1'b0; addr_i = '0; wr_data_type_i = '0; wr_data_i = '0;
      step(); step();
      check("reset_busy", 128'(busy_o), 128'(1'b0));
      check("reset_rdy", 128'(data_rdy_o), 128'(1'b0));
      check("reset_rd_data", rd_data_o, 128'h0);
      check("reset_err", 128'(err_v), 128'(1'b0));
      rst = 1'b0;

      foreach (lanes[i])
         for (int unsigned w = 0; w < 4; w++)
            txn(1'b0, 1'b1, lanes[i]*16 + w*4, 2'b10, init_word(lanes[i], w), lane, err);
      data_chk = 1'b1;

      // accept at cycle 0, pulse at cycle LATENCY
      rd_i = 1'b1; addr_i = 32'h0; busy_n = 0; pulse_at = -1;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (busy_o) busy_n++;
         if (data_rdy_o) begin
            pulse_at = c;
            lane = rd_data_o;
            rd_i = 1'b0;
         end
      end
      check("latency_pulse_cycle", 128'(pulse_at), 128'(4));
      check("latency_busy_cycles", 128'(busy_n), 128'(4));
      check("lane0_word0", 128'(lane[31:0]), 128'(32'hC0DE_0000));

      // reset mid-WAIT drops the pending store
      wr_i = 1'b1; addr_i = 32'h40; wr_data_type_i = 2'b10; wr_data_i = 32'hDEAD_BEEF;
      step(); step();
      rst = 1'b1; wr_i = 1'b0;
      step();
      check("midrst_busy", 128'(busy_o), 128'(1'b0));
      check("midrst_rdy", 128'(data_rdy_o), 128'(1'b0));
      check("midrst_rd_data", rd_data_o, 128'h0);
      rst = 1'b0;
      step();
      txn(1'b1, 1'b0, 32'h40, 2'b11, 32'h0, lane, err);
      check("midrst_no_commit", 128'(lane[31:0]), 128'(32'hC0DE_0400));

      // word then byte overlay
      txn(1'b0, 1'b1, 32'h104, 2'b10, 32'h1122_3344, lane, err);
      txn(1'b0, 1'b1, 32'h107, 2'b00, 32'h0000_00AA, lane, err);
      txn(1'b1, 1'b0, 32'h100, 2'b11, 32'h0, lane, err);
      check("byte_overlay", 128'(lane[63:32]), 128'(32'hAA22_3344));
      check("overlay_word0", 128'(lane[31:0]), 128'(32'hC0DE_1000));

      // held request: exactly one pulse
      rd_i = 1'b1; addr_i = 32'h10; pulses = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (data_rdy_o) begin pulses++; rd_i = 1'b0; end
      end
      check("held_one_pulse", 128'(pulses), 128'(1));

      // extra rd_i pulse while busy is ignored
      rd_i = 1'b1; addr_i = 32'h20; pulses = 0;
      for (int c = 1; c <= 12; c++) begin
         step();
         rd_i = (c == 2);
         if (data_rdy_o) pulses++;
      end
      check("busy_pulse_ignored", 128'(pulses), 128'(1));

      // address wrap onto lane 1
      txn(1'b1, 1'b0, 32'h10, 2'b11, 32'h0, lane_a, err);
      txn(1'b1, 1'b0, NUM_LANES*16 + 32'h10, 2'b11, 32'h0, lane, err);
      check("wrap_same_lane", lane, lane_a);
      check("wrap_word0", 128'(lane[31:0]), 128'(32'hC0DE_0100));

      // misaligned half store
      txn(1'b0, 1'b1, 32'h21, 2'b01, 32'h0000_BEEF, lane, err);
`ifdef SEGRE_MEM_MISALIGN_CHECK_EN
      check("misalign_err", 128'(err), 128'(1'b1));
      check("misalign_unchanged", lane, 128'hC0DE0203_C0DE0202_C0DE0201_C0DE0200);
`else
      check("misalign_aligned", 128'(lane[31:0]), 128'(32'hC0DE_BEEF));
      check("misalign_rest", lane[127:32], 96'hC0DE0203_C0DE0202_C0DE0201);
`endif
      txn(1'b1, 1'b0, 32'h20, 2'b11, 32'h0, lane, err);
      check("misalign_readback_err", 128'(err), 128'(1'b0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end
endmodule
